pdu_input_cond: RTL and testbench

- Conditions the raw board switches and buttons before they reach the processor debug unit (PDU): run, step, valid and in[4:0].
- Each channel gets a two-flop synchroniser and a per-channel debounce state machine, and produces a clean level plus single-cycle rise and fall pulses.
- An auto-repeat generator lets a held step button produce repeated single-step requests.
- Sits directly upstream of the PDU. Its level outputs drive the PDU's run/step/valid/in inputs.

---
 rtl/pdu_input_cond.sv | 183 ++++++++++++++++++
 tb/tb_pdu_input_cond.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pdu_input_cond.sv
// Purpose : synchronise and debounce the PDU board inputs (run, step, valid, in[4:0]);
//           per-channel clean level plus one-cycle rise/fall pulses, and step auto-repeat.
// Latency : a raw change stable from edge e0 moves the level at edge e0+DB_CYCLES+2.
// Backpr. : none; pulses are single-cycle and unconditioned, the consumer must sample every cycle.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   run_raw, step_raw, valid_raw      raw switch/button inputs
//   in_raw[4:0]                       raw data switches
//   run, step, valid, in[4:0]         debounced levels
//   rise[7:0], fall[7:0]              one-cycle edge pulses (0-4 in, 5 valid, 6 step, 7 run)
//   step_rep                          one-cycle step request: step rise plus auto-repeats
module pdu_input_cond #(
   parameter int DB_CYCLES     = 1000000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 20000000,
   parameter int CNT_W         = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_raw,
   input  logic       step_raw,
   input  logic       valid_raw,
   input  logic [4:0] in_raw,
   output logic       run,
   output logic       step,
   output logic       valid,
   output logic [4:0] in,
   output logic [7:0] rise,
   output logic [7:0] fall,
   output logic       step_rep
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   localparam int CH_STEP = 6;
   localparam int CH_RUN  = 7;

   typedef enum logic [1:0] {S_LO, W_HI, S_HI, W_LO} db_state_t;

   logic [7:0]       raw_vec;
   logic [7:0]       sync1;
   logic [7:0]       sync2;
   db_state_t        st_q   [8];
   db_state_t        st_d   [8];
   logic [CNT_W-1:0] cnt_q  [8];
   logic [CNT_W-1:0] cnt_d  [8];
   logic [7:0]       lvl;
   logic [7:0]       lvl_d;
   logic [7:0]       rise_d;
   logic [7:0]       fall_d;

   // auto-repeat state
   logic             armed;      // set by a step rise seen with run low
   logic             rep_phase;  // 0: waiting HOLD_CYCLES, 1: periodic repeats
   logic [CNT_W-1:0] hold_cnt;

   assign raw_vec = {run_raw, step_raw, valid_raw, in_raw};

   // two-flop synchroniser; the debounce FSMs only ever look at sync2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_vec;
         sync2 <= sync1;
      end
   end

   // debounce next-state: a W_ state needs DB_CYCLES+1 consecutive agreeing samples;
   // any disagreement drops back to the stable state and the count restarts from 0
   always_comb begin
      rise_d = '0;
      fall_d = '0;
      lvl    = '0;
      lvl_d  = '0;
      for (int i = 0; i < 8; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         case (st_q[i])
            S_LO: begin
               if (sync2[i]) begin
                  st_d[i]  = W_HI;
                  cnt_d[i] = '0;
               end
            end
            W_HI: begin
               if (!sync2[i]) begin
                  st_d[i]  = S_LO;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  st_d[i]   = S_HI;
                  cnt_d[i]  = '0;
                  rise_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            S_HI: begin
               if (!sync2[i]) begin
                  st_d[i]  = W_LO;
                  cnt_d[i] = '0;
               end
            end
            W_LO: begin
               if (sync2[i]) begin
                  st_d[i]  = S_HI;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  st_d[i]   = S_LO;
                  cnt_d[i]  = '0;
                  fall_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               st_d[i]  = S_LO;
               cnt_d[i] = '0;
            end
         endcase
         lvl[i]   = (st_q[i] == S_HI) || (st_q[i] == W_LO);
         lvl_d[i] = (st_d[i] == S_HI) || (st_d[i] == W_LO);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            st_q[i]  <= S_LO;
            cnt_q[i] <= '0;
         end
         rise <= '0;
         fall <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         rise <= rise_d;
         fall <= fall_d;
      end
   end

   assign {run, step, valid, in} = lvl;

   // Auto-repeat uses the next-cycle levels so that a step fall or run rise
   // suppresses a repeat landing on the same edge. armed is only set by a
   // step rise with run low, so dropping run while step is held stays silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed     <= 1'b0;
         rep_phase <= 1'b0;
         hold_cnt  <= '0;
         step_rep  <= 1'b0;
      end else if (!lvl_d[CH_STEP] || lvl_d[CH_RUN]) begin
         armed     <= 1'b0;
         rep_phase <= 1'b0;
         hold_cnt  <= '0;
         step_rep  <= 1'b0;
      end else if (rise_d[CH_STEP]) begin
         armed     <= 1'b1;
         rep_phase <= 1'b0;
         hold_cnt  <= '0;
         step_rep  <= 1'b1;
      end else if (armed) begin
         if (hold_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
            rep_phase <= 1'b1;
            hold_cnt  <= '0;
            step_rep  <= 1'b1;
         end else begin
            hold_cnt  <= hold_cnt + 1'b1;
            step_rep  <= 1'b0;
         end
      end else begin
         step_rep <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pdu_input_cond.sv
// Purpose : directed self-checking bench for pdu_input_cond with short debounce/repeat timings.
// Latency : levels expected DB_CYCLES+2 = 6 edges after a raw change is first sampled.
// Backpr. : none.
module tb_pdu_input_cond;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_raw, step_raw, valid_raw;
   logic [4:0] in_raw;
   logic       run, step, valid, step_rep;
   logic [4:0] in;
   logic [7:0] rise, fall;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int rise_cnt [8];
   int fall_cnt [8];
   int rep_q [$];
   int rise6_cyc = 0;

   pdu_input_cond #(
      .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .run_raw(run_raw), .step_raw(step_raw), .valid_raw(valid_raw), .in_raw(in_raw),
      .run(run), .step(step), .valid(valid), .in(in),
      .rise(rise), .fall(fall), .step_rep(step_rep)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < 8; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
   end

   // pulse recorder, sampled mid-cycle
   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rise[i] === 1'b1) rise_cnt[i] = rise_cnt[i] + 1;
         if (fall[i] === 1'b1) fall_cnt[i] = fall_cnt[i] + 1;
      end
      if (step_rep === 1'b1) rep_q.push_back(cyc);
      if (rise[6] === 1'b1) rise6_cyc = cyc;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int r6, f6, f5, r5, r0, rb;
      int exp_off [6];
      exp_off[0] = 0;  exp_off[1] = 20; exp_off[2] = 28;
      exp_off[3] = 36; exp_off[4] = 44; exp_off[5] = 52;

      // reset with every raw input high
      rst = 1'b1;
      run_raw = 1'b1; step_raw = 1'b1; valid_raw = 1'b1; in_raw = 5'h1F;
      repeat (3) tick();
      chk("reset_outputs", {8'h0, run, step, valid, in, rise, fall, step_rep}, 32'h0);
      repeat (4) tick();
      chk("reset_held", {run, step, valid, in, rise, fall}, 32'h0);

      rst = 1'b0;
      tick();                 // e0: first sample of the high inputs
      repeat (5) tick();      // e0+5
      chk("post_rst_lvl_e5", {run, step, valid, in}, 32'h00);
      tick();                 // e0+6
      chk("post_rst_lvl_e6", {run, step, valid, in}, 32'hFF);
      chk("post_rst_rise", rise, 32'hFF);
      tick();
      chk("post_rst_rise_1cyc", rise, 32'h00);
      chk("post_rst_no_rep", rep_q.size(), 0);

      // return everything low
      run_raw = 1'b0; step_raw = 1'b0; valid_raw = 1'b0; in_raw = 5'h00;
      repeat (10) tick();
      chk("all_low", {run, step, valid, in}, 32'h00);
      chk("all_fall_cnt", {fall_cnt[7][3:0], fall_cnt[6][3:0], fall_cnt[2][3:0], fall_cnt[0][3:0]},
          32'h1111);

      // clean edge on in[2]
      in_raw[2] = 1'b1;
      tick();
      repeat (5) tick();
      chk("in2_rise_e5", in[2], 1'b0);
      tick();
      chk("in2_rise_e6", in, 5'h04);
      chk("in2_rise_pulse", rise, 8'h04);
      tick();
      chk("in2_rise_1cyc", rise, 8'h00);
      in_raw[2] = 1'b0;
      tick();
      repeat (5) tick();
      chk("in2_fall_e5", in[2], 1'b1);
      tick();
      chk("in2_fall_e6", in, 5'h00);
      chk("in2_fall_pulse", fall, 8'h04);
      tick();
      chk("in2_fall_1cyc", fall, 8'h00);

      // step bounce: 2-cycle toggles for 12 cycles, then held high
      r6 = rise_cnt[6]; f6 = fall_cnt[6]; rb = rep_q.size();
      for (int k = 0; k < 6; k++) begin
         step_raw = ~step_raw;
         repeat (2) tick();
      end
      chk("bounce_no_lvl", step, 1'b0);
      step_raw = 1'b1;
      repeat (10) tick();
      chk("bounce_lvl", step, 1'b1);
      chk("bounce_rise_cnt", rise_cnt[6] - r6, 1);
      chk("bounce_rep_cnt", rep_q.size() - rb, 1);
      chk("bounce_no_fall", fall_cnt[6] - f6, 0);
      step_raw = 1'b0;
      repeat (10) tick();
      chk("bounce_release", step, 1'b0);
      chk("bounce_release_fall", fall_cnt[6] - f6, 1);
      chk("bounce_rep_total", rep_q.size() - rb, 1);

      // 3-cycle glitch on valid
      r5 = rise_cnt[5]; f5 = fall_cnt[5];
      valid_raw = 1'b1;
      repeat (3) tick();
      valid_raw = 1'b0;
      repeat (10) tick();
      chk("glitch_lvl", valid, 1'b0);
      chk("glitch_rise", rise_cnt[5] - r5, 0);
      chk("glitch_fall", fall_cnt[5] - f5, 0);

      // auto-repeat: step raw held 70 cycles; the level stays high until
      // 76 edges after the press, so repeats at R+60 and R+68 also land
      rb = rep_q.size(); f6 = fall_cnt[6];
      step_raw = 1'b1;
      repeat (70) tick();
      step_raw = 1'b0;
      repeat (10) tick();
      chk("rep_total", rep_q.size() - rb, 8);
      if (rep_q.size() - rb >= 6) begin
         for (int k = 0; k < 6; k++)
            chk($sformatf("rep_off_%0d", k), rep_q[rb + k] - rise6_cyc, exp_off[k]);
      end
      chk("rep_fall_once", fall_cnt[6] - f6, 1);
      rb = rep_q.size();
      repeat (30) tick();
      chk("rep_after_release", rep_q.size() - rb, 0);

      // run suppression
      run_raw = 1'b1;
      repeat (8) tick();
      chk("run_lvl", run, 1'b1);
      r6 = rise_cnt[6]; rb = rep_q.size();
      step_raw = 1'b1;
      repeat (50) tick();
      chk("runsup_rise", rise_cnt[6] - r6, 1);
      chk("runsup_no_rep", rep_q.size() - rb, 0);
      run_raw = 1'b0;
      repeat (30) tick();
      chk("runsup_run_low", run, 1'b0);
      chk("runsup_drop_no_rep", rep_q.size() - rb, 0);
      step_raw = 1'b0;
      repeat (10) tick();
      step_raw = 1'b1;
      repeat (10) tick();
      chk("runsup_repress_rep", rep_q.size() - rb, 1);
      step_raw = 1'b0;
      repeat (10) tick();

      // reset in the middle of a debounce
      r0 = rise_cnt[0];
      in_raw[0] = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      chk("mid_rst_no_rise", rise_cnt[0] - r0, 0);
      chk("mid_rst_lvl", in[0], 1'b0);
      rst = 1'b0;
      tick();
      repeat (5) tick();
      chk("mid_rst_e5", in[0], 1'b0);
      tick();
      chk("mid_rst_e6", in[0], 1'b1);
      chk("mid_rst_rise", rise, 8'h01);
      tick();
      chk("mid_rst_rise_total", rise_cnt[0] - r0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
